// File: rtl/riscv_single_cycle.sv
// Single-cycle RV32I-subset core with on-chip instruction and data memories.
// With start=1, each clock edge retires one instruction.
// With start=0, the core is halted. Up/Down move pc and Imem_write_en programs IMEM[pc].
//
// Handshake: there is none. Every input is sampled level-wise on the rising
// edge of clk. Outputs are valid whenever they are observed.
module riscv_single_cycle #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_INIT  = "imem.mem"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Imem_write_instr,
  input  logic        Imem_write_en,
  input  logic        Up,
  input  logic        Down,
  output logic [31:0] pc,
  output logic [31:0] write_back_data
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // IMEM contents are not loaded from IMEM_INIT by this RTL.
  // An implementation flow may attach an initial image to imem_q.
  // Otherwise, IMEM is filled through the front-panel port.
  if (IMEM_INIT != "") begin : g_imem_preload
  end

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] regs_q [32];
  logic [31:0] pc_q, pc_d;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4;

  logic [31:0] alu_b, alu_res;
  logic        alu_valid;
  logic        br_taken, br_valid;

  logic [31:0] mem_addr, dmem_rdata;
  logic        rd_we, dmem_we;
  logic [31:0] wb_val, next_pc;
  logic        unused_bits;

  // Instruction fetch and field extraction. The IMEM index wraps with the low pc bits.
  assign instr  = imem_q[pc_q[IAW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Data memory: word access only, so the byte offset and upper address bits are dropped.
  assign mem_addr    = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign dmem_rdata  = dmem_q[mem_addr[DAW+1:2]];
  assign unused_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  // ALU shared by OP and OP-IMM. alu_valid flags unsupported funct7 encodings.
  always_comb begin
    alu_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
    alu_res   = 32'd0;
    alu_valid = 1'b1;
    if (opcode == OPC_OP) begin
      alu_valid = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (funct3 == 3'b001) begin
      alu_valid = (funct7 == 7'b0000000);
    end else if (funct3 == 3'b101) begin
      alu_valid = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    end
    case (funct3)
      3'b000:  alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = funct7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0])
                                   : rs1_val >> alu_b[4:0];
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  // Branch condition evaluation. funct3 values 010 and 011 are not branches.
  always_comb begin
    br_taken = 1'b0;
    br_valid = 1'b1;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_valid = 1'b0;
    endcase
  end

  // Main decode. Each instruction selects its writeback value, store enable and next pc.
  // Any unsupported encoding falls through as a NOP.
  always_comb begin
    rd_we   = 1'b0;
    dmem_we = 1'b0;
    wb_val  = 32'd0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        rd_we  = 1'b1;
        wb_val = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        wb_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          wb_val  = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OPC_BRANCH: begin
        if (br_valid && br_taken) next_pc = pc_q + imm_b;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we  = 1'b1;
          wb_val = dmem_rdata;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) dmem_we = 1'b1;
      end
      OPC_OPIMM, OPC_OP: begin
        if (alu_valid) begin
          rd_we  = 1'b1;
          wb_val = alu_res;
        end
      end
      default: ;
    endcase
  end

  // pc source: the executed instruction in run mode, otherwise the front-panel stepping.
  // Up takes priority over Down.
  always_comb begin
    pc_d = pc_q;
    if (start)     pc_d = next_pc;
    else if (Up)   pc_d = pc_q + 32'd4;
    else if (Down) pc_d = pc_q - 32'd4;
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'd0;
    else        pc_q <= pc_d;
  end

  // Register file commit in run mode. x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (start && rd_we && rd != 5'd0) begin
      regs_q[rd] <= wb_val;
    end
  end

  // IMEM is written only from the front panel while halted.
  // The write uses the pc value from before this edge.
  always_ff @(posedge clk) begin
    if (reset && !start && Imem_write_en) imem_q[pc_q[IAW+1:2]] <= Imem_write_instr;
  end

  // DMEM store commit in run mode. DMEM has no reset.
  always_ff @(posedge clk) begin
    if (reset && start && dmem_we) dmem_q[mem_addr[DAW+1:2]] <= rs2_val;
  end

  assign pc              = pc_q;
  assign write_back_data = (reset && start && rd_we) ? wb_val : 32'd0;

endmodule

// File: tb/tb_riscv_single_cycle.sv
// Directed bench for riscv_single_cycle.
// It clears and programs IMEM through the front panel, then runs short programs.
// Edit-mode stepping, reset and wrap-around are exercised as well.
module tb_riscv_single_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] imem_wr_instr;
  logic        imem_wr_en;
  logic        up;
  logic        down;
  logic [31:0] pc;
  logic [31:0] wbd;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog    [15];
  logic [31:0] exp_wbd [10];

  riscv_single_cycle #(
    .IMEM_WORDS(64),
    .DMEM_WORDS(64),
    .IMEM_INIT ("")
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .Imem_write_instr(imem_wr_instr),
    .Imem_write_en   (imem_wr_en),
    .Up              (up),
    .Down            (down),
    .pc              (pc),
    .write_back_data (wbd)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_and_up(input logic [31:0] w);
    imem_wr_instr = w;
    imem_wr_en    = 1'b1;
    up            = 1'b1;
    step();
    imem_wr_en    = 1'b0;
    up            = 1'b0;
  endtask

  initial begin
    prog = '{32'h00500093,  // 0  addi x1,x0,5
             32'h00308113,  // 1  addi x2,x1,3
             32'h00000463,  // 2  beq  x0,x0,+8
             32'h00100193,  // 3  addi x3,x0,1 (skipped)
             32'hFF1FF0EF,  // 4  jal  x1,-16
             32'hDEADC2B7,  // 5  lui  x5,0xDEADC
             32'hEEF28293,  // 6  addi x5,x5,-273
             32'h00502223,  // 7  sw   x5,4(x0)
             32'h00402303,  // 8  lw   x6,4(x0)
             32'h405003B3,  // 9  sub  x7,x0,x5
             32'h4042D413,  // 10 srai x8,x5,4
             32'h005034B3,  // 11 sltu x9,x0,x5
             32'h0002A533,  // 12 slt  x10,x5,x0
             32'h00700013,  // 13 addi x0,x0,7
             32'h000005B3}; // 14 add  x11,x0,x0
    exp_wbd = '{32'hDEADC000, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h21524111,
                32'hFDEADBEE, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000000};

    reset = 1'b1; start = 1'b0; imem_wr_en = 1'b0; imem_wr_instr = 32'd0;
    up = 1'b0; down = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_pc", pc, 32'd0);
    check_eq("rst_wbd", wbd, 32'd0);
    repeat (2) step();
    reset = 1'b1;

    // Clear all of IMEM to NOPs. pc then wraps past the 64-word space.
    for (int i = 0; i < 64; i++) write_and_up(32'd0);
    check_eq("clear_pc", pc, 32'd256);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_pc", pc, 32'd0);
    check_eq("async_rst_wbd", wbd, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) write_and_up(prog[i]);
    check_eq("prog_pc", pc, 32'd60);
    down = 1'b1;
    repeat (15) step();
    down = 1'b0;
    check_eq("down_to_0", pc, 32'd0);

    // Run addi/addi/beq/jal.
    start = 1'b1;
    #1;
    check_eq("run0_pc", pc, 32'd0);
    check_eq("run0_wbd", wbd, 32'd5);
    step();
    check_eq("run1_pc", pc, 32'd4);
    check_eq("run1_wbd", wbd, 32'd8);
    step();
    check_eq("beq_pc", pc, 32'd8);
    check_eq("beq_wbd", wbd, 32'd0);
    step();
    check_eq("jal_pc", pc, 32'd16);
    check_eq("jal_wbd", wbd, 32'd20);
    step();
    check_eq("jal_tgt_pc", pc, 32'd0);
    check_eq("rerun_wbd", wbd, 32'd5);

    // Navigate to word 5 and run lui/addi/sw/lw plus the ALU and x0 cases.
    start = 1'b0;
    up = 1'b1;
    repeat (5) step();
    up = 1'b0;
    check_eq("nav_pc", pc, 32'd20);
    start = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("alu_wbd_%0d", i + 5), wbd, exp_wbd[i]);
      step();
    end
    check_eq("alu_end_pc", pc, 32'd60);

    // NOPs until pc=128.
    for (int i = 0; i < 17; i++) begin
      if (i < 3) check_eq("nop_wbd", wbd, 32'd0);
      step();
    end
    check_eq("nop_pc", pc, 32'd128);

    // Edit mode.
    start = 1'b0;
    up = 1'b1;
    repeat (3) step();
    up = 1'b0;
    check_eq("edit_up3", pc, 32'd140);
    write_and_up(32'h00AE0E13);
    check_eq("edit_wr_pc", pc, 32'd144);
    down = 1'b1;
    repeat (4) step();
    down = 1'b0;
    check_eq("edit_down4", pc, 32'd128);
    up = 1'b1;
    repeat (3) step();
    up = 1'b0;
    check_eq("edit_back140", pc, 32'd140);
    check_eq("edit_wbd_zero", wbd, 32'd0);

    // Resume at pc=140 with x28=0.
    start = 1'b1;
    #1;
    check_eq("resume_wbd", wbd, 32'd10);
    step();
    check_eq("resume_pc", pc, 32'd144);

    // Imem_write_en while running must be ignored.
    imem_wr_en = 1'b1;
    imem_wr_instr = 32'h00AE0E13;
    #1;
    check_eq("run_we_wbd", wbd, 32'd0);
    step();
    imem_wr_en = 1'b0;
    check_eq("run_we_pc", pc, 32'd148);
    start = 1'b0;
    down = 1'b1;
    step();
    down = 1'b0;
    check_eq("back144", pc, 32'd144);
    start = 1'b1;
    #1;
    check_eq("imem_unchanged", wbd, 32'd0);
    start = 1'b0;

    // Up and Down together advance by 4.
    up = 1'b1;
    down = 1'b1;
    step();
    up = 1'b0;
    down = 1'b0;
    check_eq("updown_pc", pc, 32'd148);

    // Reset mid-run.
    start = 1'b1;
    step();
    check_eq("prerst_pc", pc, 32'd152);
    #2 reset = 1'b0;
    #1;
    check_eq("midrun_rst_pc", pc, 32'd0);
    check_eq("midrun_rst_wbd", wbd, 32'd0);
    start = 1'b0;
    reset = 1'b1;

    // Down at pc=0 wraps. Fetch comes from IMEM[63].
    down = 1'b1;
    step();
    down = 1'b0;
    check_eq("wrap_down_pc", pc, 32'hFFFFFFFC);
    imem_wr_instr = 32'h00900613;  // addi x12,x0,9
    imem_wr_en = 1'b1;
    step();
    imem_wr_en = 1'b0;
    check_eq("wrap_hold_pc", pc, 32'hFFFFFFFC);
    start = 1'b1;
    #1;
    check_eq("wrap_fetch_wbd", wbd, 32'd9);
    step();
    check_eq("wrap_pc", pc, 32'd0);
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
